// File: rtl/q1_tff_div_if.sv
// q1_tff_div_if: the control and observation bundle of the q1 TFF clock divider.
//   t           : toggle/count enable (master -> divider)
//   half_period : enabled clk cycles per clk2 half period, 0 means 1 (master -> divider)
//   clk2        : divided clock, registered (divider -> master)
//   tick        : one-cycle pulse coincident with each clk2 change (divider -> master)
//   count       : current half-period counter value (divider -> master)
interface q1_tff_div_if #(
  parameter int CNT_WIDTH = 24
);
  logic                 t;
  logic [CNT_WIDTH-1:0] half_period;
  logic                 clk2;
  logic                 tick;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output t, half_period,
    input  clk2, tick, count
  );

  modport slave (
    input  t, half_period,
    output clk2, tick, count
  );
endinterface

// File: rtl/q1_tff_div.sv
// q1_tff_div: toggle-flip-flop clock divider. clk2 toggles every
// max(half_period,1) enabled clk cycles, giving a 50% duty divided clock.
// clk2 is a data output only; nothing here is clocked by it.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : q1_tff_div_if slave (t, half_period in; clk2, tick, count out)
module q1_tff_div #(
  parameter int CNT_WIDTH = 24
) (
  input logic           clk,
  input logic           reset,
  q1_tff_div_if.slave   bus
);

  // Declaration initialisers give the FPGA power-up state, so clk2 divides
  // correctly from time 0 even if reset is never asserted.
  logic [CNT_WIDTH-1:0] cnt    = '0;
  logic                 clk2_q = 1'b0;
  logic                 tick_q = 1'b0;
  logic [CNT_WIDTH-1:0] last;

  // last = eff_n - 1 with eff_n = max(half_period, 1); compared with >= so a
  // half_period lowered below cnt toggles at once instead of wrapping.
  always_comb begin
    last = '0;
    if (bus.half_period != '0)
      last = bus.half_period - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      clk2_q <= 1'b0;
      tick_q <= 1'b0;
    end else if (bus.t && (cnt >= last)) begin
      cnt    <= '0;
      clk2_q <= ~clk2_q;
      tick_q <= 1'b1;
    end else if (bus.t) begin
      cnt    <= cnt + CNT_WIDTH'(1);
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign bus.clk2  = clk2_q;
  assign bus.tick  = tick_q;
  assign bus.count = cnt;

endmodule

// File: tb/tb_q1_tff_div.sv
`timescale 1ns/1ns
module tb_q1_tff_div;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset;

  q1_tff_div_if #(.CNT_WIDTH(W)) bus ();

  q1_tff_div #(.CNT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Board clock: 66.67 ms period.
  initial forever #33333333 clk = ~clk;

  typedef struct packed {
    logic         clk2;
    logic         tick;
    logic [W-1:0] count;
  } obs_t;

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position within the current half period plus output level.
  int unsigned m_cnt  = 0;
  bit          m_clk2 = 1'b0;
  bit          m_tick = 1'b0;

  task automatic step(input bit r, input bit en, input int unsigned hp);
    int unsigned eff;
    obs_t e;
    reset           = r;
    bus.t           = en;
    bus.half_period = W'(hp);
    eff = (hp == 0) ? 1 : hp;
    if (r) begin
      m_cnt = 0; m_clk2 = 1'b0; m_tick = 1'b0;
    end else if (en) begin
      if (m_cnt + 1 >= eff) begin
        m_cnt = 0; m_clk2 = ~m_clk2; m_tick = 1'b1;
      end else begin
        m_cnt = m_cnt + 1; m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    e.clk2 = m_clk2; e.tick = m_tick; e.count = W'(m_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the divider presents outputs every cycle; check #1 after each edge.
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    a.clk2 = bus.clk2; a.tick = bus.tick; a.count = bus.count;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_underflow at %0t: got clk2=%0b tick=%0b count=%0d, nothing expected",
               $time, a.clk2, a.tick, a.count);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_out at %0t: got clk2=%0b tick=%0b count=%0d, expected clk2=%0b tick=%0b count=%0d",
                 $time, a.clk2, a.tick, a.count, e.clk2, e.tick, e.count);
      end
    end
  end

  initial begin
    int guard;
    int unsigned hp;
    reset = 1'b0;
    bus.t = 1'b1;
    bus.half_period = W'(1);
    #1;
    // Power-up without reset: registers start at 0.
    vectors++;
    if (bus.clk2 !== 1'b0 || bus.tick !== 1'b0 || bus.count !== '0) begin
      miscompares++;
      $display("FAIL powerup_state: got clk2=%0b tick=%0b count=%0d, expected 0 0 0",
               bus.clk2, bus.tick, bus.count);
    end
    // Power-up divide-by-2 with reset never asserted.
    repeat (6) step(0, 1, 1);

    // Divide-by-2 after reset.
    repeat (2) step(1, 1, 1);
    repeat (8) step(0, 1, 1);

    // Divide-by-6.
    step(1, 1, 3);
    repeat (13) step(0, 1, 3);

    // Zero treated as one.
    step(1, 1, 0);
    repeat (6) step(0, 1, 0);

    // Enable gating: freeze at count 2 for 5 cycles.
    step(1, 1, 4);
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin step(0, 1, 4); guard++; end
    repeat (5) step(0, 0, 4);
    repeat (6) step(0, 1, 4);

    // Mid-operation reset at count 7.
    step(1, 1, 10);
    guard = 0;
    while (m_cnt != 7 && guard < 30) begin step(0, 1, 10); guard++; end
    step(1, 1, 10);
    repeat (3) step(0, 1, 10);

    // Shrink half_period from 10 to 3 at count 7: toggle next edge, no wrap.
    step(1, 1, 10);
    guard = 0;
    while (m_cnt != 7 && guard < 30) begin step(0, 1, 10); guard++; end
    repeat (7) step(0, 1, 3);

    // Randomized: occasional half_period changes, gaps in t, rare resets.
    hp = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) hp = $urandom_range(0, 7);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0, hp);
    end

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (q.size() != 0 && guard < 4) begin @(negedge clk); guard++; end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
